// File: rtl/mult_8x8_seq.sv
// Sequential 8x8 signed shift-add multiplier: drives an external 9-bit adder
// stage and produces a 16-bit product in A:B after 16 cycles.
module mult_8x8_seq (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic [7:0] Din,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_fn,
    input  logic [8:0] add_s,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       X,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] a_reg, a_next;
    logic [7:0] b_reg, b_next;
    logic [7:0] m_reg, m_next;
    logic       x_reg, x_next;
    logic [2:0] cnt_reg, cnt_next;

    // X:A:B viewed as one 17-bit word; one-place arithmetic right shift
    // drops B[0] and keeps X as the new top bit of A.
    logic [16:0] xab;
    logic [15:0] ab_shr;

    assign xab = {x_reg, a_reg, b_reg};

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_shr
            assign ab_shr[gi] = xab[gi+1];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= S_IDLE;
            a_reg     <= 8'd0;
            b_reg     <= 8'd0;
            m_reg     <= 8'd0;
            x_reg     <= 1'b0;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            m_reg     <= m_next;
            x_reg     <= x_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        m_next     = m_reg;
        x_next     = x_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            S_IDLE: begin
                // Run wins over ClearA_LoadB so B keeps its multiplier value.
                if (Run) begin
                    x_next     = 1'b0;
                    a_next     = 8'd0;
                    m_next     = Din;
                    cnt_next   = 3'd0;
                    state_next = S_ADD;
                end else if (ClearA_LoadB) begin
                    x_next = 1'b0;
                    a_next = 8'd0;
                    b_next = Din;
                end
            end
            S_ADD: begin
                if (b_reg[0]) begin
                    {x_next, a_next} = add_s;
                end
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                a_next = ab_shr[15:8];
                b_next = ab_shr[7:0];
                if (cnt_reg == 3'd7) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next   = cnt_reg + 3'd1;
                    state_next = S_ADD;
                end
            end
            S_DONE: begin
                if (ClearA_LoadB) begin
                    x_next = 1'b0;
                    a_next = 8'd0;
                    b_next = Din;
                end
                if (!Run) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The last multiplier bit carries negative weight, hence the subtract.
    assign add_fn = (state_reg == S_ADD) && (cnt_reg == 3'd7);
    assign add_a  = a_reg;
    assign add_b  = m_reg;
    assign Aval   = a_reg;
    assign Bval   = b_reg;
    assign X      = x_reg;
    assign Busy   = (state_reg == S_ADD) || (state_reg == S_SHIFT);
    assign Done   = (state_reg == S_DONE);

endmodule

// File: tb/tb_mult_8x8_seq.sv
// Directed bench for mult_8x8_seq with a behavioural 9-bit adder stage.
module tb_mult_8x8_seq;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Din;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_fn;
    logic [8:0] add_s;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       Busy;
    logic       Done;

    int checks;
    int errors;

    mult_8x8_seq dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Run         (Run),
        .ClearA_LoadB(ClearA_LoadB),
        .Din         (Din),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_fn      (add_fn),
        .add_s       (add_s),
        .Aval        (Aval),
        .Bval        (Bval),
        .X           (X),
        .Busy        (Busy),
        .Done        (Done)
    );

    // Sign-extended adder/subtractor stage the controller expects.
    assign add_s = add_fn ? ({add_a[7], add_a} - {add_b[7], add_b})
                          : ({add_a[7], add_a} + {add_b[7], add_b});

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Load B, start with M, and count edges after the start edge until Done.
    // Leaves Run high. Also records add_fn activity during the run.
    task automatic run_mult(input logic [7:0] b, input logic [7:0] m,
                            output int cycles, output int fn_cnt, output int fn_pos);
        Run          = 1'b0;
        ClearA_LoadB = 1'b1;
        Din          = b;
        tick(1);
        ClearA_LoadB = 1'b0;
        Run          = 1'b1;
        Din          = m;
        tick(1);
        cycles = 0;
        fn_cnt = 0;
        fn_pos = -1;
        while (!Done && cycles < 40) begin
            if (add_fn) begin
                fn_cnt++;
                fn_pos = cycles;
            end
            tick(1);
            cycles++;
        end
    endtask

    task automatic test_reset;
        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        Din          = 8'h00;
        tick(2);
        Reset = 1'b0;
        checks++;
        if ({Aval, Bval, X, Busy, Done, add_fn, add_a, add_b} !== 28'd0) begin
            errors++;
            $display("FAIL reset_state: A=%h B=%h X=%b Busy=%b Done=%b fn=%b add_a=%h add_b=%h, required all zero",
                     Aval, Bval, X, Busy, Done, add_fn, add_a, add_b);
        end
        $display("reset: A=%h B=%h X=%b Busy=%b Done=%b", Aval, Bval, X, Busy, Done);
    endtask

    task automatic test_pos_neg;
        int cyc, fc, fp;
        run_mult(8'hFD, 8'h07, cyc, fc, fp);
        checks++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL posneg_latency: got %0d cycles, required 16", cyc);
        end
        checks++;
        if ({Done, Busy, Aval, Bval, X} !== {1'b1, 1'b0, 8'hFF, 8'hEB, 1'b1}) begin
            errors++;
            $display("FAIL posneg_result: Done=%b Busy=%b A=%h B=%h X=%b, required 1 0 ff eb 1",
                     Done, Busy, Aval, Bval, X);
        end
        $display("mult B=fd M=07: cycles=%0d A=%h B=%h X=%b", cyc, Aval, Bval, X);
    endtask

    task automatic test_neg128;
        int cyc, fc, fp;
        run_mult(8'h80, 8'h80, cyc, fc, fp);
        checks++;
        if ({Aval, Bval, X} !== {8'h40, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL neg128_result: A=%h B=%h X=%b, required 40 00 0", Aval, Bval, X);
        end
        checks++;
        if (fc !== 1 || fp !== 14) begin
            errors++;
            $display("FAIL neg128_add_fn: high %0d times at cycle %0d, required once at cycle 14", fc, fp);
        end
        $display("mult B=80 M=80: cycles=%0d A=%h B=%h X=%b fn_cnt=%0d fn_pos=%0d",
                 cyc, Aval, Bval, X, fc, fp);
    endtask

    task automatic test_edges;
        logic [7:0] vb [3];
        logic [7:0] vm [3];
        logic [15:0] vexp [3];
        int cyc, fc, fp;
        vb[0] = 8'hFF; vm[0] = 8'hFF; vexp[0] = 16'h0001;
        vb[1] = 8'h7F; vm[1] = 8'h7F; vexp[1] = 16'h3F01;
        vb[2] = 8'h00; vm[2] = 8'h5A; vexp[2] = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            run_mult(vb[i], vm[i], cyc, fc, fp);
            checks++;
            if ({Aval, Bval} !== vexp[i] || X !== vexp[i][15] || cyc !== 16) begin
                errors++;
                $display("FAIL edge_%0d: A:B=%h X=%b cycles=%0d, required %h X=%b cycles=16",
                         i, {Aval, Bval}, X, cyc, vexp[i], vexp[i][15]);
            end
            $display("mult B=%h M=%h: cycles=%0d A:B=%h X=%b", vb[i], vm[i], cyc, {Aval, Bval}, X);
        end
    endtask

    task automatic test_hold_run;
        logic [15:0] snap;
        int bad;
        snap = {Aval, Bval};
        bad  = 0;
        Run  = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick(1);
            if ({Aval, Bval} !== 16'h0000 || Done !== 1'b1 || Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_run: %0d unstable cycles, A:B=%h Done=%b Busy=%b, required A:B=0000 Done=1 Busy=0",
                     bad, {Aval, Bval}, Done, Busy);
        end
        $display("hold run 22 cycles: start A:B=%h end A:B=%h Done=%b", snap, {Aval, Bval}, Done);
    endtask

    task automatic test_clear_while_busy;
        int cyc;
        Run          = 1'b0;
        ClearA_LoadB = 1'b1;
        Din          = 8'h03;
        tick(1);
        ClearA_LoadB = 1'b0;
        Run          = 1'b1;
        Din          = 8'h05;
        tick(1);
        tick(3);
        ClearA_LoadB = 1'b1;
        Din          = 8'hAA;
        tick(4);
        ClearA_LoadB = 1'b0;
        cyc = 7;
        while (!Done && cyc < 40) begin
            tick(1);
            cyc++;
        end
        checks++;
        if ({Aval, Bval, X} !== {16'h000F, 1'b0} || cyc !== 16) begin
            errors++;
            $display("FAIL clear_busy: A:B=%h X=%b cycles=%0d, required 000f X=0 cycles=16",
                     {Aval, Bval}, X, cyc);
        end
        $display("mult B=03 M=05 with clear pulses while busy: A:B=%h", {Aval, Bval});
    endtask

    task automatic test_drop_restart;
        int cyc;
        Run = 1'b0;
        Din = 8'h02;
        tick(1);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || {Aval, Bval} !== 16'h000F) begin
            errors++;
            $display("FAIL drop_run: Done=%b Busy=%b A:B=%h, required 0 0 000f", Done, Busy, {Aval, Bval});
        end
        Run = 1'b1;
        tick(1);
        checks++;
        if (Busy !== 1'b1 || add_b !== 8'h02 || Aval !== 8'h00) begin
            errors++;
            $display("FAIL restart_start: Busy=%b add_b=%h A=%h, required 1 02 00", Busy, add_b, Aval);
        end
        cyc = 0;
        while (!Done && cyc < 40) begin
            tick(1);
            cyc++;
        end
        checks++;
        if ({Aval, Bval} !== 16'h001E || cyc !== 16) begin
            errors++;
            $display("FAIL restart_result: A:B=%h cycles=%0d, required 001e cycles=16", {Aval, Bval}, cyc);
        end
        $display("restart with previous B=0f, M=02: A:B=%h cycles=%0d", {Aval, Bval}, cyc);
        ClearA_LoadB = 1'b1;
        Din          = 8'h55;
        tick(1);
        ClearA_LoadB = 1'b0;
        checks++;
        if ({Aval, Bval, X, Done} !== {8'h00, 8'h55, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_in_done: A=%h B=%h X=%b Done=%b, required 00 55 0 1", Aval, Bval, X, Done);
        end
        $display("clear/load in done: A=%h B=%h Done=%b", Aval, Bval, Done);
    endtask

    task automatic test_simultaneous;
        int cyc;
        Run          = 1'b0;
        ClearA_LoadB = 1'b1;
        Din          = 8'h04;
        tick(1);
        Run          = 1'b1;
        ClearA_LoadB = 1'b1;
        Din          = 8'h03;
        tick(1);
        ClearA_LoadB = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Bval !== 8'h04 || add_b !== 8'h03) begin
            errors++;
            $display("FAIL simul_start: Busy=%b B=%h M=%h, required 1 04 03", Busy, Bval, add_b);
        end
        cyc = 0;
        while (!Done && cyc < 40) begin
            tick(1);
            cyc++;
        end
        checks++;
        if ({Aval, Bval} !== 16'h000C) begin
            errors++;
            $display("FAIL simul_result: A:B=%h, required 000c", {Aval, Bval});
        end
        $display("simultaneous Run+ClearA_LoadB, B=04 M=03: A:B=%h", {Aval, Bval});
    endtask

    task automatic test_reset_midop;
        Run          = 1'b0;
        ClearA_LoadB = 1'b1;
        Din          = 8'hFF;
        tick(1);
        ClearA_LoadB = 1'b0;
        Run          = 1'b1;
        Din          = 8'h7F;
        tick(1);
        tick(4);
        checks++;
        if (Busy !== 1'b1 || add_a === 8'h00) begin
            errors++;
            $display("FAIL midop_progress: Busy=%b A=%h, required Busy=1 and nonzero A", Busy, add_a);
        end
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
        Run   = 1'b0;
        checks++;
        if ({Aval, Bval, X, Busy, Done, add_fn, add_a, add_b} !== 28'd0) begin
            errors++;
            $display("FAIL midop_reset: A=%h B=%h X=%b Busy=%b Done=%b M=%h, required all zero",
                     Aval, Bval, X, Busy, Done, add_b);
        end
        tick(1);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL midop_idle: Busy=%b Done=%b, required 0 0", Busy, Done);
        end
        $display("reset mid-ADD: A=%h B=%h Busy=%b Done=%b", Aval, Bval, Busy, Done);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        Din          = 8'h00;
        test_reset;
        test_pos_neg;
        test_neg128;
        test_edges;
        test_hold_run;
        test_clear_while_busy;
        test_drop_restart;
        test_simultaneous;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_8x8_seq.md
# mult_8x8_seq

Sequential 8×8 signed (two's-complement) shift-add multiplier controller and datapath. It drives the 9-bit combinational adder/subtractor stage with operands and consumes its 9-bit sign-extended sum. It produces a 16-bit signed product in the concatenated A:B register pair after a fixed 16-cycle sequence. It sits between the switch/button inputs and the hex-display/LED outputs of the multiplier lab top level.

## Interface
Parameters: none. Width is fixed at 8 to match the adder stage.

- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- Run  in  1  start request; level, sampled each edge
- ClearA_LoadB  in  1  clears X and A, loads B from Din; level, sampled each edge
- Din  in  8  multiplier operand (loaded into B) or multiplicand (latched into M at start)
- add_a  out  8  adder operand A; equals register A (combinational)
- add_b  out  8  adder operand B; equals register M (combinational)
- add_fn  out  1  1 = subtract (A − M), 0 = add; 1 only in ADD state when bit counter = 7
- add_s  in  9  sign-extended adder result {carry-extended sign, sum[7:0]}
- Aval  out  8  register A (product high byte)
- Bval  out  8  register B (product low byte)
- X  out  1  sign-extension flip-flop
- Busy  out  1  high in ADD and SHIFT states
- Done  out  1  high in DONE state

## Operation
Registers:
- A[7:0], B[7:0], M[7:0], X
- 3-bit bit counter cnt
- State: IDLE, ADD, SHIFT, DONE

IDLE:
- Run=1: X←0, A←0, M←Din, cnt←0, go to ADD. Run has priority over ClearA_LoadB in the same cycle.
- Run=0 and ClearA_LoadB=1: X←0, A←0, B←Din, stay in IDLE.

ADD:
- If B[0]=1: {X,A}←add_s. add_fn is 1 when cnt=7, giving the final-bit correction subtract for signed multipliers.
- If B[0]=0: registers hold.
- Always go to SHIFT.

SHIFT:
- Arithmetic right shift of X:A:B: A←{X,A[7:1]}, B←{A[0],B[7:1]}, X unchanged.
- If cnt=7, go to DONE; otherwise cnt←cnt+1 and go to ADD.

DONE:
- Hold all registers.
- Run=0: go to IDLE.
- Run held high: stay in DONE. There is no retrigger; the product is stable.
- ClearA_LoadB is honoured in DONE with the same action as in IDLE.

Arithmetic rules:
- Result {A,B} is the exact 16-bit two's-complement product of the M and B values held at start.
- X equals A[7] after completion.
- −128×−128 = +16384 must be exact; the 9-bit adder result prevents overflow.

Additional rules:
- ClearA_LoadB is ignored in ADD and SHIFT.
- Din changes while Busy have no effect, because M is latched at start.

## Timing
- Reset (takes effect at the edge): A=0, B=0, M=0, X=0, cnt=0, state IDLE, Busy=0, Done=0, add_fn=0, add_a=0, add_b=0.
- Reset mid-operation: the next edge aborts to IDLE with all registers zeroed. No partial product survives.
- Start edge E0 (Run=1 in IDLE): Busy=1 after E0.
- ADD and SHIFT alternate on edges E1..E16, which is exactly 16 cycles regardless of multiplier bit pattern.
- After E16: state DONE, Done=1, Busy=0, {A,B} valid.
- Done stays high until the first edge that sees Run=0. It deasserts one cycle after Run falls.
- add_a, add_b and add_fn are combinational from registers and state. add_s is sampled at the ADD-state edge, so the adder path must close in one clock.
- A new Run pulse is accepted only from IDLE. The earliest restart is the edge after Run is seen low in DONE.

## Test plan
- Reset check: assert Reset for 2 cycles from any state, including mid-ADD → A=B=M=X=0, Done=0, Busy=0, state IDLE.
- Positive × negative: Reset; ClearA_LoadB with Din=0xFD (−3); Run with Din=0x07 → after 16 cycles Done=1, Aval=0xFF, Bval=0xEB, X=1 (−21).
- Both −128: B=0x80, M=0x80 → A=0x40, B=0x00, X=0 (+16384). Also confirm add_fn=1 only during the ADD state with cnt=7.
- Edge operands: B=0xFF, M=0xFF → A=0x00, B=0x01. B=0x7F, M=0x7F → A=0x3F, B=0x01. B=0x00, any M → A=B=0.
- Run and ClearA_LoadB interactions:
  - Hold Run high after Done → registers stable for 20+ cycles and no second multiply.
  - Pulse ClearA_LoadB while Busy → no effect on A or B.
  - Drop Run → IDLE next edge.
  - Raise Run again → a new multiply uses the previous product's B as the multiplier.
- Simultaneous inputs: Run=1 and ClearA_LoadB=1 on the same edge in IDLE → multiply starts and B is not reloaded from Din.
